// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encoding and default datapath width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_pkg;

    localparam int ALU_WIDTH = 32;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLT = 3'b101,
        ALU_SLL = 3'b110,
        ALU_SRL = 3'b111
    } alu_op_e;

endpackage

// File: rtl/alu_if.sv
// ALU operand/result bundle: rs1, rs2, ctrl, in_valid in; rd, z, rd_q, z_q, out_valid out.
// Latency: rd/z are combinational; rd_q/z_q/out_valid are one cycle after in_valid.
// Backpressure: none, so there is no ready signal.
interface alu_if
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
);
    logic [WIDTH-1:0] rs1;
    logic [WIDTH-1:0] rs2;
    logic [2:0]       ctrl;
    logic             in_valid;
    logic [WIDTH-1:0] rd;
    logic             z;
    logic [WIDTH-1:0] rd_q;
    logic             z_q;
    logic             out_valid;

    // master drives operands, slave (the ALU) drives results
    modport master (
        output rs1, rs2, ctrl, in_valid,
        input  rd, z, rd_q, z_q, out_valid
    );

    modport slave (
        input  rs1, rs2, ctrl, in_valid,
        output rd, z, rd_q, z_q, out_valid
    );
endinterface

// File: rtl/alu_shifter.sv
// Logical barrel shifter: rs1 shifted by shamt, dir=0 left, dir=1 right (zero fill).
// Latency: combinational. Ports: rs1, shamt, dir in; result out.
// Backpressure: none.
module alu_shifter #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]         rs1,
    input  logic [$clog2(WIDTH)-1:0] shamt,
    input  logic                     dir,
    output logic [WIDTH-1:0]         result
);

    assign result = dir ? (rs1 >> shamt) : (rs1 << shamt);

endmodule

// File: rtl/alu.sv
// Integer ALU: ADD/SUB/AND/OR/XOR/SLT/SLL/SRL on bus.rs1/rs2 selected by bus.ctrl.
// Latency: bus.rd/bus.z combinational; bus.rd_q/z_q/out_valid registered, 1 cycle.
// Backpressure: none; an operation is accepted on every clk edge with in_valid=1.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic  clk,
    input  logic  rst_n,
    alu_if.slave  bus
);

    localparam int SHAMT_W = $clog2(WIDTH);

    logic [WIDTH-1:0] shift_res;
    logic [WIDTH-1:0] result;
    logic             slt_lt;

    // Only the low shamt bits of rs2 select the shift distance; upper bits are ignored.
    alu_shifter #(
        .WIDTH (WIDTH)
    ) u_shifter (
        .rs1    (bus.rs1),
        .shamt  (bus.rs2[SHAMT_W-1:0]),
        .dir    (bus.ctrl == ALU_SRL),
        .result (shift_res)
    );

    // Direct signed compare rather than the sign of rs1-rs2, so overflow cannot flip it.
    assign slt_lt = $signed(bus.rs1) < $signed(bus.rs2);

    always_comb begin
        result = bus.rs1 + bus.rs2;
        case (alu_op_e'(bus.ctrl))
            ALU_ADD: result = bus.rs1 + bus.rs2;
            ALU_SUB: result = bus.rs1 - bus.rs2;
            ALU_AND: result = bus.rs1 & bus.rs2;
            ALU_OR:  result = bus.rs1 | bus.rs2;
            ALU_XOR: result = bus.rs1 ^ bus.rs2;
            ALU_SLT: result = {{(WIDTH-1){1'b0}}, slt_lt};
            ALU_SLL: result = shift_res;
            ALU_SRL: result = shift_res;
            default: result = bus.rs1 + bus.rs2;
        endcase
    end

    assign bus.rd = result;
    assign bus.z  = (result == '0);

    // Results hold when idle; out_valid is a single-cycle strobe per accepted op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rd_q      <= '0;
            bus.z_q       <= 1'b0;
            bus.out_valid <= 1'b0;
        end else begin
            bus.out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                bus.rd_q <= result;
                bus.z_q  <= (result == '0);
            end
        end
    end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vectors, reset cases, then random ops vs a reference model.
// Latency: expects combinational rd/z and a one-cycle registered path.
// Backpressure: none exercised; in_valid may be high every cycle.
module tb_alu;
    import alu_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    // reference copy of registered outputs
    logic [31:0] m_rdq;
    logic        m_zq;
    logic        m_ov;

    alu_if #(.WIDTH(32)) bus ();

    alu #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference behaviour from plain arithmetic: signed compare via widened integers.
    function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        sa = a;
        sb = b;
        if (a[31]) sa = sa - 64'sd4294967296;
        if (b[31]) sb = sb - 64'sd4294967296;
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return (sa < sb) ? 32'd1 : 32'd0;
            3'd6: return a << (b % 32);
            default: return a >> (b % 32);
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    // Drive one op between edges, check combinational result, then the registered outputs.
    task automatic step(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic v);
        logic [31:0] exp;
        @(negedge clk);
        bus.ctrl     = op;
        bus.rs1      = a;
        bus.rs2      = b;
        bus.in_valid = v;
        exp = ref_alu(op, a, b);
        #1;
        check({tag, ".rd"}, bus.rd, exp);
        check({tag, ".z"}, 32'(bus.z), 32'(exp == 32'd0));
        if (v) begin
            m_rdq = exp;
            m_zq  = (exp == 32'd0);
        end
        m_ov = v;
        @(posedge clk);
        #1;
        check({tag, ".rd_q"}, bus.rd_q, m_rdq);
        check({tag, ".z_q"}, 32'(bus.z_q), 32'(m_zq));
        check({tag, ".out_valid"}, 32'(bus.out_valid), 32'(m_ov));
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        v;

        checks = 0;
        errors = 0;
        m_rdq  = '0;
        m_zq   = 1'b0;
        m_ov   = 1'b0;

        rst_n        = 1'b0;
        bus.rs1      = '0;
        bus.rs2      = '0;
        bus.ctrl     = 3'd0;
        bus.in_valid = 1'b0;
        #1;
        check("reset.rd_q", bus.rd_q, 32'd0);
        check("reset.z_q", 32'(bus.z_q), 32'd0);
        check("reset.out_valid", 32'(bus.out_valid), 32'd0);

        @(negedge clk);
        rst_n = 1'b1;

        // directed vectors
        step("add",       ALU_ADD, 32'd20, 32'd30, 1'b1);
        step("sub",       ALU_SUB, 32'd20, 32'd30, 1'b1);
        step("sub_eq",    ALU_SUB, 32'd30, 32'd30, 1'b1);
        step("and",       ALU_AND, 32'd20, 32'd30, 1'b1);
        step("or",        ALU_OR,  32'd20, 32'd30, 1'b1);
        step("xor",       ALU_XOR, 32'd20, 32'd30, 1'b1);
        step("slt_lt",    ALU_SLT, 32'd20, 32'd30, 1'b1);
        step("slt_ge",    ALU_SLT, 32'd30, 32'd20, 1'b1);
        step("slt_min",   ALU_SLT, 32'h8000_0000, 32'd1, 1'b1);
        step("slt_ovf",   ALU_SLT, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        step("sll_mask",  ALU_SLL, 32'd1, 32'h21, 1'b1);
        step("srl_31",    ALU_SRL, 32'h8000_0000, 32'd31, 1'b1);
        step("sll_zero",  ALU_SLL, 32'hDEAD_BEEF, 32'h40, 1'b1);
        step("srl_zero",  ALU_SRL, 32'hDEAD_BEEF, 32'd0, 1'b1);
        step("hold",      ALU_XOR, 32'h1234_5678, 32'h0F0F_0F0F, 1'b0);
        step("add_wrap",  ALU_ADD, 32'hFFFF_FFFF, 32'd1, 1'b1);
        step("add_nz",    ALU_ADD, 32'd20, 32'd30, 1'b1);

        // asynchronous reset between edges while a capture is pending
        @(negedge clk);
        bus.ctrl     = ALU_ADD;
        bus.rs1      = 32'd5;
        bus.rs2      = 32'd7;
        bus.in_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        m_rdq = '0;
        m_zq  = 1'b0;
        m_ov  = 1'b0;
        check("arst.rd_q", bus.rd_q, 32'd0);
        check("arst.z_q", 32'(bus.z_q), 32'd0);
        check("arst.out_valid", 32'(bus.out_valid), 32'd0);
        check("arst.comb_rd", bus.rd, 32'd12);
        @(posedge clk);
        #1;
        check("arst_hold.rd_q", bus.rd_q, 32'd0);
        check("arst_hold.out_valid", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        rst_n        = 1'b1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst.out_valid", 32'(bus.out_valid), 32'd0);
        check("post_rst.rd_q", bus.rd_q, 32'd0);
        step("first_cap", ALU_SUB, 32'd100, 32'd1, 1'b1);

        // random ops, some with equal operands to exercise the zero flag
        for (int i = 0; i < 300; i++) begin
            op = 3'($urandom);
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? a : 32'($urandom);
            if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(0, 3));
            v  = ($urandom_range(0, 3) != 0);
            step("rand", op, a, b, v);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
